// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: adds two WORD_BYTES-byte operands by sending them one
// byte slice at a time through an external registered 8-bit CLA. Each slice
// takes one issue cycle plus ADD_LATENCY wait cycles, and the carry is chained
// from one slice to the next.
// Optional feature: define CLA_SEQ_OVERFLOW_EN to add the out_ovf output
// (signed-overflow flag for the completed word).
module cla_word_sequencer #(
    parameter int WORD_BYTES  = 4,
    parameter int ADD_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*WORD_BYTES-1:0] in_a,
    input  logic [8*WORD_BYTES-1:0] in_b,
    input  logic                    in_cin,
    output logic [7:0]              add_a,
    output logic [7:0]              add_b,
    output logic                    add_cin,
    input  logic [7:0]              add_sum,
    input  logic                    add_cout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*WORD_BYTES-1:0] out_sum,
    output logic                    out_cout
`ifdef CLA_SEQ_OVERFLOW_EN
    ,
    output logic                    out_ovf
`endif
);

    localparam int         W         = 8 * WORD_BYTES;
    localparam logic [2:0] K_LAST    = 3'(WORD_BYTES - 1);
    localparam logic [1:0] WAIT_LAST = 2'(ADD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] a_q, b_q, sum_q;
    logic         carry_q;
    logic [2:0]   k_q;
    logic [1:0]   wait_q;
    logic         accept, sample, last_slice;
    logic [2:0]   issue_k;
    logic [7:0]   issue_a_d, issue_b_d;
    logic         issue_cin_d;
    logic [7:0]   add_a_q, add_b_q;
    logic         add_cin_q;

    // Selects byte idx of a word. A loop over constant offsets keeps every
    // part-select in range whatever the index value is.
    function automatic logic [7:0] byte_of(input logic [W-1:0] w, input logic [2:0] idx);
        byte_of = 8'h00;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (idx == 3'(i)) byte_of = w[8*i +: 8];
        end
    endfunction

    assign accept     = (state_q == IDLE) && in_valid;
    assign sample     = (state_q == WAIT) && (wait_q == WAIT_LAST);
    assign last_slice = (k_q == K_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: one issue cycle and ADD_LATENCY wait cycles per slice.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (sample) state_d = last_slice ? DONE : ISSUE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs, decoded from the state. Reset masks in_ready at once.
    always_comb begin
        in_ready  = (state_q == IDLE) && !reset;
        out_valid = (state_q == DONE);
    end

    // Operands for the next issue. On accept the registers are not loaded
    // yet, so slice 0 comes from the inputs; later slices take the next byte
    // and the carry the adder is returning right now.
    always_comb begin
        issue_k     = (state_q == IDLE) ? 3'd0 : k_q + 3'd1;
        issue_a_d   = (state_q == IDLE) ? in_a[7:0] : byte_of(a_q, issue_k);
        issue_b_d   = (state_q == IDLE) ? in_b[7:0] : byte_of(b_q, issue_k);
        issue_cin_d = (state_q == IDLE) ? in_cin : add_cout;
    end

    // Adder interface flops: they hold a slice only while in ISSUE, zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            add_a_q   <= 8'h00;
            add_b_q   <= 8'h00;
            add_cin_q <= 1'b0;
        end else if (state_d == ISSUE) begin
            add_a_q   <= issue_a_d;
            add_b_q   <= issue_b_d;
            add_cin_q <= issue_cin_d;
        end else begin
            add_a_q   <= 8'h00;
            add_b_q   <= 8'h00;
            add_cin_q <= 1'b0;
        end
    end

    // Operand capture, wait counter, slice index, carry chain and result assembly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= 3'd0;
            wait_q  <= 2'd0;
        end else begin
            if (accept) begin
                a_q     <= in_a;
                b_q     <= in_b;
                carry_q <= in_cin;
                k_q     <= 3'd0;
            end
            if (state_q == ISSUE) begin
                wait_q <= 2'd0;
            end else if ((state_q == WAIT) && !sample) begin
                wait_q <= wait_q + 2'd1;
            end
            if (sample) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (k_q == 3'(i)) sum_q[8*i +: 8] <= add_sum;
                end
                carry_q <= add_cout;
                if (!last_slice) k_q <= k_q + 3'd1;
            end
        end
    end

    assign add_a    = add_a_q;
    assign add_b    = add_b_q;
    assign add_cin  = add_cin_q;
    assign out_sum  = sum_q;
    assign out_cout = carry_q;

`ifdef CLA_SEQ_OVERFLOW_EN
    // Signed overflow: the operands share a sign and the result sign differs.
    // It is built from held registers, so it is stable in DONE and 0 after reset.
    assign out_ovf = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);
`endif

endmodule

// File: doc/cla_word_sequencer.md
CLA_WORD_SEQUENCER -- requirements
Module: cla_word_sequencer

Interface
REQ-001 The block SHALL have parameter WORD_BYTES, default 4: number of 8-bit slices per word (legal values 1..8).
REQ-002 The block SHALL have parameter ADD_LATENCY, default 2: cycles from add_a/add_b/add_cin presentation to valid add_sum/add_cout (legal values 1..4).
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_a (input, 8*WORD_BYTES), in_b (input, 8*WORD_BYTES) and in_cin (input, 1): operand request channel.
REQ-006 The block SHALL have ports add_a (output, 8), add_b (output, 8) and add_cin (output, 1): operand slice driven to the registered 8-bit CLA; these SHALL be driven from flops.
REQ-007 The block SHALL have ports add_sum (input, 8) and add_cout (input, 1): result returned by the registered 8-bit CLA.
REQ-008 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_sum (output, 8*WORD_BYTES) and out_cout (output, 1): result channel.

Function
REQ-009 FSM states SHALL be IDLE, ISSUE, WAIT and DONE.
REQ-010 in_ready SHALL be 1 only in IDLE; in_valid&in_ready SHALL capture in_a, in_b and in_cin, clear the slice index k to 0, set the carry register to in_cin, and go to ISSUE.
REQ-011 ISSUE SHALL last exactly one cycle, presenting add_a=a[8k+7:8k], add_b=b[8k+7:8k] and add_cin=carry register; the next state SHALL be WAIT.
REQ-012 WAIT SHALL count ADD_LATENCY-1 cycles, then sample add_sum into sum slice k and add_cout into the carry register; the sample cycle SHALL be exactly ADD_LATENCY cycles after the ISSUE cycle.
REQ-013 After a sample, the block SHALL go to ISSUE with k+1 if k<WORD_BYTES-1; otherwise it SHALL go to DONE with out_cout=final carry.
REQ-014 Throughput: each slice SHALL cost ADD_LATENCY+1 cycles; out_valid SHALL first assert 1+WORD_BYTES*(ADD_LATENCY+1) cycles after the accept edge (13 at default parameters).
REQ-015 In DONE, out_valid SHALL be 1 and out_sum/out_cout SHALL be held stable until out_valid&out_ready; the block SHALL then return to IDLE (one-cycle bubble before the next accept).
REQ-016 Outside ISSUE, add_a, add_b and add_cin SHALL be 0.
REQ-017 Arithmetic SHALL be unsigned modulo 2^(8*WORD_BYTES), with the carry of the top slice reported on out_cout.
REQ-018 in_valid asserted outside IDLE SHALL be ignored; operands SHALL NOT be re-sampled mid-operation.

Reset
REQ-019 Reset SHALL force IDLE, k=0 and a zero carry register, and drive in_ready=0 while asserted and 1 on the first cycle after deassertion.
REQ-020 Reset SHALL drive out_valid=0, out_sum=0, out_cout=0, add_a=0, add_b=0 and add_cin=0.
REQ-021 Reset asserted in ISSUE, WAIT or DONE SHALL abandon the operation; no partial result SHALL ever appear with out_valid=1.

Configuration
REQ-022 With CLA_SEQ_OVERFLOW_EN defined, the block SHALL add output out_ovf (1 bit) = (a[MSB]==b[MSB]) && (out_sum[MSB]!=a[MSB]), with the same timing, hold and reset as out_sum (reset value 0).
REQ-023 Without CLA_SEQ_OVERFLOW_EN, the out_ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-024 With defaults: a=0xFFFFFFFF, b=0x00000001, cin=0 -> out_sum=0x00000000, out_cout=1, out_valid 13 cycles after accept.
REQ-025 a=0x12345678, b=0x9ABCDEF0, cin=1 -> out_sum=0xACF13569, out_cout=0; slice-0 ISSUE shows add_a=0x78, add_b=0xF0, add_cin=1.
REQ-026 a=0x000000FF, b=0x00000001 -> slice-1 ISSUE shows add_cin=1; out_sum=0x00000100.
REQ-027 Hold out_ready=0 for 5 cycles in DONE -> out_sum/out_cout stable and in_ready=0; with out_ready=1 -> IDLE next cycle, and a new in_valid is accepted the following cycle.
REQ-028 Assert reset in WAIT of slice 2 -> all outputs 0 and state IDLE; a following transaction 0x00000001+0x00000001 -> out_sum=0x00000002.
REQ-029 With CLA_SEQ_OVERFLOW_EN: 0x7FFFFFFF+0x00000001 -> out_sum=0x80000000, out_ovf=1; 0xFFFFFFFF+0x00000001 -> out_ovf=0.
